exec_unit_mc: RTL and testbench

EXEC_UNIT_MC -- requirements
Module: exec_unit_mc

---
 rtl/exec_unit_mc.sv | 201 ++++++++++++++++++++
 tb/tb_exec_unit_mc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_mc.sv
// exec_unit_mc: valid/ready execution unit with single-cycle ALU ops and a shift-add multiplier.
// Define EXEC_UNIT_DIV_EN to add an unsigned restoring divider on aluctrl 10010.
module exec_unit_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d1_in,
    input  logic [WIDTH-1:0] d2_in,
    input  logic [4:0]       aluctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d1_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             zero
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    typedef enum logic [4:0] {
        OP_AND   = 5'b00000,
        OP_OR    = 5'b00001,
        OP_ADD   = 5'b00010,
        OP_SUB   = 5'b00110,
        OP_PASSB = 5'b00111,
        OP_NOR   = 5'b01100,
        OP_SLL   = 5'b01101,
        OP_SRL   = 5'b01110,
        OP_SRA   = 5'b01111,
        OP_SLT   = 5'b10000,
        OP_MUL   = 5'b10001,
        OP_DIV   = 5'b10010
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [4:0]       op_q, op_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             is_multi;
    logic [WIDTH-1:0] sub_res;
    logic             slt;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   mul_sum;

    assign sub_res = d1_in - d2_in;
    assign slt     = $signed(d1_in) < $signed(d2_in);
    assign shamt   = d2_in[SHW-1:0];

    // One shift-add step: add the multiplicand when the current multiplier bit is set,
    // then shift the (WIDTH+1)-bit sum right into the low product word.
    assign mul_sum = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

`ifdef EXEC_UNIT_DIV_EN
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] rem_sub;
    logic           rem_ge;

    assign rem_sh  = {hi_q, lo_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, b_q};
    assign rem_ge  = rem_sh >= {1'b0, b_q};
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_res  = '0;
        alu_zero = 1'b0;
        is_multi = 1'b0;
        case (aluctrl)
            OP_ADD:   alu_res = d1_in + d2_in;
            OP_SUB: begin
                alu_res  = sub_res;
                alu_zero = (sub_res == '0);
            end
            OP_AND:   alu_res = d1_in & d2_in;
            OP_OR:    alu_res = d1_in | d2_in;
            OP_NOR:   alu_res = ~(d1_in | d2_in);
            OP_PASSB: alu_res = d2_in;
            OP_SLL:   alu_res = d1_in << shamt;
            OP_SRL:   alu_res = d1_in >> shamt;
            OP_SRA:   alu_res = $unsigned($signed(d1_in) >>> shamt);
            OP_SLT: begin
                alu_res  = {{(WIDTH-1){1'b0}}, slt};
                alu_zero = slt;
            end
            OP_MUL:   is_multi = 1'b1;
`ifdef EXEC_UNIT_DIV_EN
            OP_DIV:   is_multi = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d    = d1_in;
                    b_d    = d2_in;
                    op_d   = aluctrl;
                    cnt_d  = '0;
                    zero_d = alu_zero;
                    hi_d   = '0;
                    if (is_multi) begin
                        state_d = S_BUSY;
                        lo_d    = '0;
`ifdef EXEC_UNIT_DIV_EN
                        if (aluctrl == OP_DIV) lo_d = d1_in;
`endif
                    end else begin
                        state_d = S_DONE;
                        lo_d    = alu_res;
                    end
                end
            end
            S_BUSY: begin
                case (op_q)
                    OP_MUL: begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                        b_d  = b_q >> 1;
                    end
`ifdef EXEC_UNIT_DIV_EN
                    OP_DIV: begin
                        // A zero divisor always subtracts, giving all-ones quotient and remainder = dividend.
                        if (rem_ge) begin
                            hi_d = rem_sub[WIDTH-1:0];
                            lo_d = {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_d = rem_sh[WIDTH-1:0];
                            lo_d = {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end
`endif
                    default: ;
                endcase
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign d1_out    = lo_q;
    assign hi_out    = hi_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed testbench for exec_unit_mc at WIDTH=32; define EXEC_UNIT_DIV_EN to also cover the divider.
module tb_exec_unit_mc;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] d1_in;
    logic [31:0] d2_in;
    logic [4:0]  aluctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d1_out;
    logic [31:0] hi_out;
    logic        zero;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    exec_unit_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d1_in     (d1_in),
        .d2_in     (d2_in),
        .aluctrl   (aluctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d1_out    (d1_out),
        .hi_out    (hi_out),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 100) begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        aluctrl  = op;
        d1_in    = a;
        d2_in    = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // cycles counts the accept edge as 1; stops when out_valid is seen or the budget runs out.
    task automatic wait_done(output int cycles, output bit ready_seen);
        cycles     = 1;
        ready_seen = 1'b0;
        while (out_valid !== 1'b1 && cycles < 200) begin
            if (in_ready !== 1'b0) ready_seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_cmp++; if (d1_out !== 32'h0) begin n_bad++; $display("FAIL reset d1_out: got %h want 0", d1_out); end
        n_cmp++; if (hi_out !== 32'h0) begin n_bad++; $display("FAIL reset hi_out: got %h want 0", hi_out); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL reset zero: got %b want 0", zero); end
    endtask

    task automatic test_sub();
        do_op(5'b00110, 32'd5, 32'd5);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sub_eq out_valid: got %b want 1", out_valid); end
        n_cmp++; if (d1_out !== 32'd0) begin n_bad++; $display("FAIL sub_eq d1_out: got %h want 0", d1_out); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL sub_eq zero: got %b want 1", zero); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL sub_eq in_ready: got %b want 0", in_ready); end
        finish_op();
        do_op(5'b00110, 32'd7, 32'd5);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sub_ne out_valid: got %b want 1", out_valid); end
        n_cmp++; if (d1_out !== 32'd2) begin n_bad++; $display("FAIL sub_ne d1_out: got %h want 2", d1_out); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL sub_ne zero: got %b want 0", zero); end
        finish_op();
    endtask

    task automatic test_shift();
        do_op(5'b01111, 32'h8000_0000, 32'd4);
        n_cmp++; if (d1_out !== 32'hF800_0000) begin n_bad++; $display("FAIL sra d1_out: got %h want f8000000", d1_out); end
        finish_op();
        do_op(5'b01110, 32'h8000_0000, 32'd4);
        n_cmp++; if (d1_out !== 32'h0800_0000) begin n_bad++; $display("FAIL srl d1_out: got %h want 08000000", d1_out); end
        finish_op();
    endtask

    task automatic test_alu();
        vec_t vecs[$];
        vecs.push_back('{op: 5'b00010, a: 32'hFFFF_FFFF, b: 32'd2,         res: 32'd1,         z: 1'b0});
        vecs.push_back('{op: 5'b00110, a: 32'd0,         b: 32'd1,         res: 32'hFFFF_FFFF, z: 1'b0});
        vecs.push_back('{op: 5'b00000, a: 32'hF0F0_1234, b: 32'h0FF0_FF00, res: 32'h00F0_1200, z: 1'b0});
        vecs.push_back('{op: 5'b00001, a: 32'hF000_0000, b: 32'h0000_000F, res: 32'hF000_000F, z: 1'b0});
        vecs.push_back('{op: 5'b01100, a: 32'h0F0F_0000, b: 32'h0000_F0F0, res: 32'hF0F0_0F0F, z: 1'b0});
        vecs.push_back('{op: 5'b00111, a: 32'd123,       b: 32'hDEAD_BEEF, res: 32'hDEAD_BEEF, z: 1'b0});
        vecs.push_back('{op: 5'b01101, a: 32'd1,         b: 32'd31,        res: 32'h8000_0000, z: 1'b0});
        vecs.push_back('{op: 5'b01101, a: 32'd3,         b: 32'h25,        res: 32'h0000_0060, z: 1'b0});
        vecs.push_back('{op: 5'b01111, a: 32'h7FFF_FFF0, b: 32'd4,         res: 32'h07FF_FFFF, z: 1'b0});
        vecs.push_back('{op: 5'b10000, a: 32'hFFFF_FFFF, b: 32'd1,         res: 32'd1,         z: 1'b1});
        vecs.push_back('{op: 5'b10000, a: 32'd1,         b: 32'hFFFF_FFFF, res: 32'd0,         z: 1'b0});
        vecs.push_back('{op: 5'b10000, a: 32'd5,         b: 32'd5,         res: 32'd0,         z: 1'b0});
        vecs.push_back('{op: 5'b00011, a: 32'd5,         b: 32'd6,         res: 32'd0,         z: 1'b0});
`ifndef EXEC_UNIT_DIV_EN
        vecs.push_back('{op: 5'b10010, a: 32'd100,       b: 32'd7,         res: 32'd0,         z: 1'b0});
`endif
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b);
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL alu[%0d] out_valid: got %b want 1", i, out_valid); end
            n_cmp++; if (d1_out !== vecs[i].res) begin n_bad++; $display("FAIL alu[%0d] d1_out: got %h want %h", i, d1_out, vecs[i].res); end
            n_cmp++; if (hi_out !== 32'h0) begin n_bad++; $display("FAIL alu[%0d] hi_out: got %h want 0", i, hi_out); end
            n_cmp++; if (zero !== vecs[i].z) begin n_bad++; $display("FAIL alu[%0d] zero: got %b want %b", i, zero, vecs[i].z); end
            finish_op();
        end
    endtask

    task automatic test_mul();
        int  cyc;
        bit  rdy;
        logic [31:0] ma[3];
        logic [31:0] mb[3];
        logic [63:0] mp[3];
        ma[0] = 32'hFFFF_FFFF; mb[0] = 32'd2;         mp[0] = 64'h0000_0001_FFFF_FFFE;
        ma[1] = 32'h0001_0000; mb[1] = 32'h0001_0000; mp[1] = 64'h0000_0001_0000_0000;
        ma[2] = 32'hFFFF_FFFF; mb[2] = 32'hFFFF_FFFF; mp[2] = 64'hFFFF_FFFE_0000_0001;
        for (int i = 0; i < 3; i++) begin
            do_op(5'b10001, ma[i], mb[i]);
            wait_done(cyc, rdy);
            n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL mul[%0d] latency: got %0d want 33", i, cyc); end
            n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL mul[%0d] in_ready during busy: got %b want 0", i, rdy); end
            n_cmp++; if (hi_out !== mp[i][63:32]) begin n_bad++; $display("FAIL mul[%0d] hi_out: got %h want %h", i, hi_out, mp[i][63:32]); end
            n_cmp++; if (d1_out !== mp[i][31:0]) begin n_bad++; $display("FAIL mul[%0d] d1_out: got %h want %h", i, d1_out, mp[i][31:0]); end
            n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL mul[%0d] zero: got %b want 0", i, zero); end
            finish_op();
        end
    endtask

`ifdef EXEC_UNIT_DIV_EN
    task automatic test_div();
        int  cyc;
        bit  rdy;
        logic [31:0] da[3];
        logic [31:0] db[3];
        logic [31:0] dq[3];
        logic [31:0] dr[3];
        da[0] = 32'd100;       db[0] = 32'd7;  dq[0] = 32'd14;        dr[0] = 32'd2;
        da[1] = 32'd9;         db[1] = 32'd0;  dq[1] = 32'hFFFF_FFFF; dr[1] = 32'd9;
        da[2] = 32'hFFFF_FFFF; db[2] = 32'd16; dq[2] = 32'h0FFF_FFFF; dr[2] = 32'd15;
        for (int i = 0; i < 3; i++) begin
            do_op(5'b10010, da[i], db[i]);
            wait_done(cyc, rdy);
            n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL div[%0d] latency: got %0d want 33", i, cyc); end
            n_cmp++; if (d1_out !== dq[i]) begin n_bad++; $display("FAIL div[%0d] quotient: got %h want %h", i, d1_out, dq[i]); end
            n_cmp++; if (hi_out !== dr[i]) begin n_bad++; $display("FAIL div[%0d] remainder: got %h want %h", i, hi_out, dr[i]); end
            finish_op();
        end
    endtask
`endif

    task automatic test_reset_mid_busy();
        do_op(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        aluctrl   = 5'b00010;
        d1_in     = 32'd1;
        d2_in     = 32'd1;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_busy in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_busy out_valid: got %b want 0", out_valid); end
        n_cmp++; if (d1_out !== 32'h0) begin n_bad++; $display("FAIL rst_busy d1_out: got %h want 0", d1_out); end
        n_cmp++; if (hi_out !== 32'h0) begin n_bad++; $display("FAIL rst_busy hi_out: got %h want 0", hi_out); end
        do_op(5'b00110, 32'd7, 32'd5);
        n_cmp++; if (d1_out !== 32'd2) begin n_bad++; $display("FAIL rst_busy post_op d1_out: got %h want 2", d1_out); end
        finish_op();
    endtask

    task automatic test_backpressure();
        do_op(5'b00010, 32'd10, 32'd20);
        in_valid = 1'b1;
        aluctrl  = 5'b00110;
        d1_in    = 32'd9;
        d2_in    = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold[%0d] out_valid: got %b want 1", i, out_valid); end
            n_cmp++; if (d1_out !== 32'd30) begin n_bad++; $display("FAIL hold[%0d] d1_out: got %h want 1e", i, d1_out); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold[%0d] in_ready: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL exit_edge out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL exit_edge in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL next_op out_valid: got %b want 1", out_valid); end
        n_cmp++; if (d1_out !== 32'd5) begin n_bad++; $display("FAIL next_op d1_out: got %h want 5", d1_out); end
        finish_op();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        d1_in     = '0;
        d2_in     = '0;
        aluctrl   = '0;
        @(negedge clk);
        test_reset();
        test_sub();
        test_shift();
        test_alu();
        test_mul();
`ifdef EXEC_UNIT_DIV_EN
        test_div();
`endif
        test_reset_mid_busy();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
